// File: rtl/mul_sequencer.sv
// Micro-sequencer that plays the shift-and-add multiply opcode program on one start pulse.
// Optional sign fix-up step pair is enabled by defining MULSEQ_SIGN_FIX_EN.
module mul_sequencer #(
   parameter int N_BITS           = 5,
   parameter int STEP_CYCLES      = 35,
   parameter int LONG_STEP_CYCLES = 100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] op_a,
   input  logic [15:0] op_b,
   input  logic [15:0] cout,
   output logic [11:0] opcode,
   output logic [15:0] mem_dat_x,
   output logic [15:0] mem_dat_y,
   output logic        busy,
   output logic        done,
   output logic [15:0] result
);

   localparam int MAX_DWELL = (STEP_CYCLES > LONG_STEP_CYCLES) ? STEP_CYCLES : LONG_STEP_CYCLES;
   localparam int DW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
   localparam int IW        = $clog2(N_BITS) + 1;

   localparam logic [11:0] OP_NOP   = 12'b000000001001;
   localparam logic [11:0] OP_LDX   = 12'b000000001011;
   localparam logic [11:0] OP_LDY   = 12'b000000001100;
   localparam logic [11:0] OP_AND0  = 12'b001000000101;
   localparam logic [11:0] OP_SHL   = 12'b001000010011;
   localparam logic [11:0] OP_SHR   = 12'b000000101010;
   localparam logic [11:0] OP_MOVB  = 12'b100001001011;
   localparam logic [11:0] OP_NEG   = 12'b001000011000;
   localparam logic [11:0] OP_MOVA  = 12'b100000001001;
   localparam logic [11:0] OP_AND1  = 12'b001110000101;
   localparam logic [11:0] OP_MOVC  = 12'b010000101100;
   localparam logic [11:0] OP_ADD   = 12'b000000000000;
   localparam logic [11:0] OP_MOVCO = 12'b010010001100;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef enum logic [3:0] {
      S_LDX, S_LDY, S_AND0, S_SHL, S_SHR, S_FIX_MOVB, S_FIX_NEG,
      S_MOVA, S_MOVB, S_AND1, S_MOVC, S_ADD, S_MOVCO
   } step_t;

   state_t          state_q, state_d;
   step_t           step_q, step_d;
   logic [DW-1:0]   dwell_q, dwell_d;
   logic [IW-1:0]   iter_q, iter_d;
   logic [11:0]     opcode_d;
   logic [15:0]     mem_dat_x_d, mem_dat_y_d, result_d;
   logic            busy_d, done_d;
   logic [DW-1:0]   last_dwell;
   logic            step_end, last_iter;

   function automatic logic [11:0] opcode_of(input step_t s);
      case (s)
         S_LDX:      return OP_LDX;
         S_LDY:      return OP_LDY;
         S_AND0:     return OP_AND0;
         S_SHL:      return OP_SHL;
         S_SHR:      return OP_SHR;
         S_FIX_MOVB: return OP_MOVB;
         S_FIX_NEG:  return OP_NEG;
         S_MOVA:     return OP_MOVA;
         S_MOVB:     return OP_MOVB;
         S_AND1:     return OP_AND1;
         S_MOVC:     return OP_MOVC;
         S_ADD:      return OP_ADD;
         S_MOVCO:    return OP_MOVCO;
         default:    return OP_NOP;
      endcase
   endfunction

   assign last_dwell = (step_q == S_MOVC) ? DW'(LONG_STEP_CYCLES - 1) : DW'(STEP_CYCLES - 1);
   assign step_end   = (dwell_q == last_dwell);
   assign last_iter  = (iter_q == IW'(N_BITS - 1));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
      state_d     = state_q;
      step_d      = step_q;
      dwell_d     = dwell_q;
      iter_d      = iter_q;
      opcode_d    = opcode;
      mem_dat_x_d = mem_dat_x;
      mem_dat_y_d = mem_dat_y;
      busy_d      = busy;
      done_d      = 1'b0;
      result_d    = result;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d     = RUN;
               step_d      = S_LDX;
               dwell_d     = '0;
               iter_d      = '0;
               mem_dat_x_d = op_a;
               mem_dat_y_d = op_b;
               busy_d      = 1'b1;
               opcode_d    = OP_LDX;
            end
         end
         RUN: begin
            if (abort) begin
               state_d  = IDLE;
               dwell_d  = '0;
               iter_d   = '0;
               busy_d   = 1'b0;
               opcode_d = OP_NOP;
            end else if (!step_end) begin
               dwell_d = dwell_q + 1'b1;
            end else begin
               dwell_d = '0;
               case (step_q)
                  S_LDX:      step_d = S_LDY;
                  S_LDY:      step_d = S_AND0;
                  S_AND0:     step_d = S_SHL;
                  S_SHL:      step_d = S_SHR;
`ifdef MULSEQ_SIGN_FIX_EN
                  S_SHR:      step_d = (last_iter && cout[15]) ? S_FIX_MOVB : S_MOVA;
`else
                  S_SHR:      step_d = S_MOVA;
`endif
                  S_FIX_MOVB: step_d = S_FIX_NEG;
                  S_FIX_NEG:  step_d = S_MOVA;
                  S_MOVA:     step_d = S_MOVB;
                  S_MOVB:     step_d = S_AND1;
                  S_AND1:     step_d = S_MOVC;
                  S_MOVC:     step_d = S_ADD;
                  S_ADD:      step_d = S_MOVCO;
                  S_MOVCO: begin
                     if (last_iter) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = cout;
                     end else begin
                        iter_d = iter_q + 1'b1;
                        step_d = S_SHL;
                     end
                  end
                  default:    step_d = S_LDX;
               endcase
               opcode_d = opcode_of(step_d);
            end
         end
         DONE: begin
            // The done cycle still holds MOVCO; the program retires on the following edge.
            state_d  = IDLE;
            step_d   = S_LDX;
            iter_d   = '0;
            busy_d   = 1'b0;
            opcode_d = OP_NOP;
         end
         default: begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            opcode_d = OP_NOP;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         step_q    <= S_LDX;
         dwell_q   <= '0;
         iter_q    <= '0;
         opcode    <= OP_NOP;
         mem_dat_x <= '0;
         mem_dat_y <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         dwell_q   <= dwell_d;
         iter_q    <= iter_d;
         opcode    <= opcode_d;
         mem_dat_x <= mem_dat_x_d;
         mem_dat_y <= mem_dat_y_d;
         busy      <= busy_d;
         done      <= done_d;
         result    <= result_d;
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer: opcode trace, latency, sign fix-up, abort, ignored starts, reset.
// Expectations follow MULSEQ_SIGN_FIX_EN when it is defined for the build.
module tb_mul_sequencer;

   localparam logic [11:0] NOP   = 12'b000000001001;
   localparam logic [11:0] LDX   = 12'b000000001011;
   localparam logic [11:0] LDY   = 12'b000000001100;
   localparam logic [11:0] AND0  = 12'b001000000101;
   localparam logic [11:0] SHL   = 12'b001000010011;
   localparam logic [11:0] SHR   = 12'b000000101010;
   localparam logic [11:0] MOVB  = 12'b100001001011;
   localparam logic [11:0] NEG   = 12'b001000011000;
   localparam logic [11:0] MOVA  = 12'b100000001001;
   localparam logic [11:0] AND1  = 12'b001110000101;
   localparam logic [11:0] MOVC  = 12'b010000101100;
   localparam logic [11:0] ADD   = 12'b000000000000;
   localparam logic [11:0] MOVCO = 12'b010010001100;

   localparam logic [11:0] IT_OP [10] = '{SHL, SHR, MOVB, NEG, MOVA, MOVB, AND1, MOVC, ADD, MOVCO};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] op_a = '0;
   logic [15:0] op_b = '0;
   logic [15:0] cout = '0;
   logic [11:0] opcode;
   logic [15:0] mem_dat_x, mem_dat_y, result;
   logic        busy, done;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cout_mode = 0;
   bit fix_exp   = 1'b0;

   int done_n, dones, errs;
   logic busy_after;
   logic [15:0] memx_mid;

   mul_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .op_a(op_a), .op_b(op_b), .cout(cout),
      .opcode(opcode), .mem_dat_x(mem_dat_x), .mem_dat_y(mem_dat_y),
      .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Expected opcode n cycles after the accepting start edge.
   function automatic logic [11:0] exp_op(input int n, input bit fix);
      int m, it, k, len;
      if (n < 35)  return LDX;
      if (n < 70)  return LDY;
      if (n < 105) return AND0;
      m  = n - 105;
      it = m / 345;
      if (it > 4) it = 4;
      k = m - it * 345;
      for (int i = 0; i < 10; i++) begin
         if ((i == 2 || i == 3) && !(fix && it == 4)) continue;
         len = (i == 7) ? 100 : 35;
         if (k < len) return IT_OP[i];
         k -= len;
      end
      return NOP;
   endfunction

   // Stub of control.Cout: mode 1 raises bit 15 during every SHR dwell.
   function automatic logic [15:0] cout_model(input int n);
      int k;
      if (cout_mode == 0) return 16'h0046;
      if (n >= 105 && n < 1830) begin
         k = (n - 105) % 345;
         if (k >= 35 && k < 70) return 16'h8000;
      end
      return 16'h0078;
   endfunction

   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Runs from relative cycle 0 (negedge after accepting edge) up to cycle 'limit'.
   task automatic monitor(input int limit, input int abort_at, input int p1, input int p2, input int p3);
      int n = 0;
      done_n = -1;
      dones = 0;
      errs = 0;
      busy_after = 1'bx;
      memx_mid = 'x;
      while (n < limit) begin
         cout = cout_model(n);
         if (done) begin
            dones++;
            if (done_n < 0) done_n = n;
         end
         if (done_n >= 0 && n == done_n + 1) busy_after = busy;
         if (n == 1000) memx_mid = mem_dat_x;
         if (done_n < 0 && (abort_at < 0 || n <= abort_at) && opcode !== exp_op(n, fix_exp)) errs++;
         abort = (n == abort_at);
         start = (n == p1 || n == p2 || n == p3);
         step();
         n++;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      rst_n = 1'b1;

      // 1: reset state and idle
      repeat (10) step();
      check("rst_opcode", opcode, NOP);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_memx", mem_dat_x, 0);

      abort = 1'b1;
      step();
      check("idle_abort_busy", busy, 0);
      check("idle_abort_op", opcode, NOP);
      start = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("abort_beats_start", busy, 0);
      step();

      // 2: plain program
      cout_mode = 0;
      fix_exp = 1'b0;
      launch(16'd5, 16'd14);
      check("t2_busy", busy, 1);
      check("t2_first_op", opcode, LDX);
      check("t2_memx", mem_dat_x, 16'd5);
      check("t2_memy", mem_dat_y, 16'd14);
      monitor(1831, -1, -1, -1, -1);
      check("t2_done_cycle", done_n, 1830);
      check("t2_done_count", dones, 1);
      check("t2_trace_errs", errs, 0);
      check("t2_result", result, 16'h0046);
      check("t2_busy_end", busy, 0);
      check("t2_op_end", opcode, NOP);

      // 3: negative operands, cout[15] high in every SHR
      cout_mode = 1;
`ifdef MULSEQ_SIGN_FIX_EN
      fix_exp = 1'b1;
`else
      fix_exp = 1'b0;
`endif
      launch(16'hFFF8, 16'hFFF1);
      monitor(1901, -1, -1, -1, -1);
      check("t3_done_cycle", done_n, fix_exp ? 1900 : 1830);
      check("t3_done_count", dones, 1);
      check("t3_trace_errs", errs, 0);
      check("t3_result", result, 16'h0078);
      check("t3_busy_end", busy, 0);

      // 4: abort at cycle 500
      cout_mode = 0;
      fix_exp = 1'b0;
      launch(16'd7, 16'd9);
      monitor(501, 500, -1, -1, -1);
      check("t4_no_done", dones, 0);
      check("t4_trace_errs", errs, 0);
      check("t4_op_nop", opcode, NOP);
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      check("t4_result_kept", result, 16'h0078);
      launch(16'd3, 16'd7);
      check("t4_restart_busy", busy, 1);
      check("t4_restart_op", opcode, LDX);

      // 5: starts at 100 and in the done cycle ignored; start at 1831 relaunches
      op_a = 16'hAAAA;
      monitor(1832, -1, 100, 1830, 1831);
      check("t5_memx_held", memx_mid, 16'd3);
      check("t5_done_cycle", done_n, 1830);
      check("t5_done_count", dones, 1);
      check("t5_trace_errs", errs, 0);
      check("t5_idle_after_done", busy_after, 0);
      check("t5_relaunch_busy", busy, 1);
      check("t5_relaunch_op", opcode, LDX);
      check("t5_relaunch_memx", mem_dat_x, 16'hAAAA);

      // 6: asynchronous reset mid-program
      monitor(700, -1, -1, -1, -1);
      check("t6_running", busy, 1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_op", opcode, NOP);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_result", result, 0);
      check("t6_rst_memx", mem_dat_x, 0);
      check("t6_rst_memy", mem_dat_y, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();
      check("t6_idle", busy, 0);
      launch(16'd5, 16'd14);
      monitor(1831, -1, -1, -1, -1);
      check("t6_done_cycle", done_n, 1830);
      check("t6_trace_errs", errs, 0);
      check("t6_result", result, 16'h0046);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
